// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one bit-serial 1101 detector between NREQ word producers.
// Define SEQ_SCHED_OVERLAP_EN to count overlapping matches; otherwise history clears after each match.
module seq_detect_sched #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  parameter int CNTW  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  hit,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [CNTW-1:0]       match_cnt
);

  localparam int BCW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDW-1:0]   r_ptr;
  logic [WIDTH-1:0] r_shift;
  logic [BCW-1:0]   r_bitcnt;
  logic [2:0]       r_hist;

  logic             w_any;
  logic [IDW-1:0]   w_win;
  logic [IDW:0]     w_idx;
  logic [IDW-1:0]   w_ptr_next;
  logic [WIDTH-1:0] w_word;
  logic             w_bit;
  logic             w_match;
  logic [2:0]       w_hist_next;
  logic             w_last;

  // Search from r_ptr upward; descending k lets the nearest requester win.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_any  = 1'b0;
    w_win  = '0;
    w_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) w_idx = w_idx - (IDW+1)'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (w_idx == (IDW+1)'(i))) begin
          w_any = 1'b1;
          w_win = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) w_word = data[i*WIDTH +: WIDTH];
    end
  end

  assign w_ptr_next = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  // Detector: three bits of history plus the bit being consumed.
  assign w_bit   = r_shift[WIDTH-1];
  assign w_match = ({r_hist, w_bit} == 4'b1101);
`ifdef SEQ_SCHED_OVERLAP_EN
  assign w_hist_next = {r_hist[1:0], w_bit};
`else
  assign w_hist_next = w_match ? 3'b000 : {r_hist[1:0], w_bit};
`endif

  assign w_last = (r_bitcnt == BCW'(WIDTH - 1));
  assign busy   = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any)  w_state_next = S_SHIFT;
      S_SHIFT: if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      hit       <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
      r_ptr     <= '0;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_hist    <= '0;
    end else begin
      gnt  <= '0;
      hit  <= 1'b0;
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            gnt       <= NREQ'(1) << w_win;
            r_shift   <= w_word;
            done_id   <= w_win;
            r_ptr     <= w_ptr_next;
            r_bitcnt  <= '0;
            match_cnt <= '0;
            r_hist    <= '0;
          end
        end
        S_SHIFT: begin
          r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
          r_bitcnt <= r_bitcnt + 1'b1;
          r_hist   <= w_hist_next;
          if (w_match) begin
            hit <= 1'b1;
            if (match_cnt != {CNTW{1'b1}}) match_cnt <= match_cnt + 1'b1;
          end
          if (w_last) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Randomised self-checking bench for seq_detect_sched against a bit-list reference model.
module tb_seq_detect_sched;
  localparam int NREQ  = 2;
  localparam int WIDTH = 8;
  localparam int CNTW  = 4;
  localparam int IDW   = 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] data = '0;
  logic [NREQ-1:0]       gnt, gnt_s;
  logic                  busy, hit, done, busy_s, hit_s, done_s;
  logic [IDW-1:0]        done_id, done_id_s;
  logic [CNTW-1:0]       match_cnt;
  logic [0:0]            match_cnt_s;

  seq_detect_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .gnt(gnt), .busy(busy),
    .hit(hit), .done(done), .done_id(done_id), .match_cnt(match_cnt));

  // Narrow-count instance sees the same traffic to exercise saturation.
  seq_detect_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .gnt(gnt_s), .busy(busy_s),
    .hit(hit_s), .done(done_s), .done_id(done_id_s), .match_cnt(match_cnt_s));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;
  int m_ptr = 0;
  int last_gnt_cyc = 0;
  int m_last_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Positions (0 = first bit consumed) where a 1101 is counted.
  function automatic logic [WIDTH-1:0] match_mask(input logic [WIDTH-1:0] w);
    int b[WIDTH];
    int last_end;
    logic [WIDTH-1:0] m;
    m = '0;
    last_end = -1;
    for (int p = 0; p < WIDTH; p++) b[p] = int'(w[WIDTH-1-p]);
    for (int p = 3; p < WIDTH; p++) begin
      if (b[p-3] == 1 && b[p-2] == 1 && b[p-1] == 0 && b[p] == 1) begin
`ifdef SEQ_SCHED_OVERLAP_EN
        m[p] = 1'b1;
`else
        if (p - 3 > last_end) begin
          m[p] = 1'b1;
          last_end = p;
        end
`endif
      end
    end
    return m;
  endfunction

  // Called with the DUT idle; returns one cycle after DONE (IDLE re-entered).
  task automatic do_txn(input logic [NREQ-1:0] rq, input logic [NREQ*WIDTH-1:0] d,
                        input bit hold, input int exp_gap);
    int win;
    int cnt;
    int sat;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] mm;
    req  = rq;
    data = d;
    win  = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (win < 0 && rq[i]) win = i;
    end
    w   = d[win*WIDTH +: WIDTH];
    mm  = match_mask(w);
    cnt = $countones(mm);
    sat = (1 << CNTW) - 1;
    @(posedge clk); #1;
    check("gnt", 32'(gnt), 32'(1 << win));
    check("busy_at_gnt", 32'(busy), 1);
    if (exp_gap > 0) check("gnt_gap", cyc - last_gnt_cyc, exp_gap);
    last_gnt_cyc = cyc;
    m_ptr = (win + 1) % NREQ;
    if (!hold) req = '0;
    for (int j = 1; j <= WIDTH; j++) begin
      @(posedge clk); #1;
      check("hit", 32'(hit), 32'(mm[j-1]));
      check("gnt_quiet", 32'(gnt), 0);
      check("done", 32'(done), 32'(j == WIDTH));
    end
    m_last_cnt = (cnt > sat) ? sat : cnt;
    check("match_cnt", 32'(match_cnt), m_last_cnt);
    check("done_id", 32'(done_id), win);
    check("match_cnt_sat", 32'(match_cnt_s), (cnt > 1) ? 1 : cnt);
    check("done_sat", 32'(done_s), 1);
    @(posedge clk); #1;
    check("done_drop", 32'(done), 0);
    check("busy_drop", 32'(busy), 0);
    check("cnt_hold", 32'(match_cnt), m_last_cnt);
  endtask

  task automatic idle_cycles(input int n);
    req = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_gnt", 32'(gnt), 0);
      check("idle_done", 32'(done), 0);
      check("idle_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_done", 32'(done), 0);
    check("rst_done_id", 32'(done_id), 0);
    check("rst_match_cnt", 32'(match_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed words from the plan.
    do_txn(2'b01, {8'h00, 8'hD0}, 1'b0, 0);
    do_txn(2'b10, {8'hDB, 8'h00}, 1'b0, 0);
    for (int i = 0; i < 4; i++) do_txn(2'b11, 16'hFFFF, 1'b1, (i == 0) ? 0 : WIDTH + 2);
    idle_cycles(1);
    do_txn(2'b01, {8'h00, 8'h0D}, 1'b0, 0);
    do_txn(2'b01, {8'h00, 8'h0D}, 1'b0, 0);
    // A trailing 110 must not combine with the next word's leading 1.
    do_txn(2'b10, {8'h06, 8'h00}, 1'b0, 0);
    do_txn(2'b10, {8'h80, 8'h00}, 1'b0, 0);
    do_txn(2'b01, {8'h00, 8'hDD}, 1'b0, 0);

    // Asynchronous reset in the middle of a word.
    req  = 2'b01;
    data = {8'h00, 8'hDD};
    @(posedge clk); #1;
    check("pre_rst_gnt", 32'(gnt), 1);
    req = '0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_cnt", 32'(match_cnt), 1);
    check("pre_rst_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_hit", 32'(hit), 0);
    check("arst_done", 32'(done), 0);
    check("arst_match_cnt", 32'(match_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    idle_cycles(WIDTH + 2);
    do_txn(2'b11, {8'hDD, 8'hDB}, 1'b0, 0);

    // Randomised traffic with occasional back-to-back held requests.
    for (int n = 0; n < 60; n++) begin
      logic [NREQ-1:0]       rq;
      logic [NREQ*WIDTH-1:0] d;
      int gap;
      rq  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      d   = ($urandom_range(0, 3) == 0) ? 16'hDBDD : (NREQ*WIDTH)'($urandom);
      gap = $urandom_range(0, 2);
      do_txn(rq, d, gap == 0, 0);
      if (gap > 0) idle_cycles(gap);
    end
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
